// File: rtl/sap_controller_ext.sv
// SAP-1 style sequencer with variable-length instructions, halt,
// single-step gating and flag-conditional jumps.
module sap_controller_ext #(
  parameter int OPCODE_W = 4,
  parameter int STAGE_W  = 3
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                carry_i,
  input  logic                zero_i,
  input  logic                step_mode_i,
  input  logic                step_i,
  output logic                pc_en_o,
  output logic                pc_inc_o,
  output logic                pc_load_o,
  output logic                mem_load_o,
  output logic                mem_en_o,
  output logic                mem_write_o,
  output logic                ins_load_o,
  output logic                ins_en_o,
  output logic                a_load_o,
  output logic                a_en_o,
  output logic                b_load_o,
  output logic                adder_en_o,
  output logic                adder_sub_o,
  output logic                flags_load_o,
  output logic                output_load_o,
  output logic                halt_o,
  output logic                instr_done_o,
  output logic [STAGE_W-1:0]  stage_o
);

  typedef enum logic [STAGE_W-1:0] {
    T1 = STAGE_W'(0),
    T2 = STAGE_W'(1),
    T3 = STAGE_W'(2),
    T4 = STAGE_W'(3),
    T5 = STAGE_W'(4),
    T6 = STAGE_W'(5)
  } stage_e;

  typedef struct packed {
    logic pc_en;
    logic pc_inc;
    logic pc_load;
    logic mem_load;
    logic mem_en;
    logic mem_write;
    logic ins_load;
    logic ins_en;
    logic a_load;
    logic a_en;
    logic b_load;
    logic adder_en;
    logic adder_sub;
    logic flags_load;
    logic output_load;
  } ctl_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_STA = 4'b0011;
  localparam logic [3:0] OP_LDI = 4'b0100;
  localparam logic [3:0] OP_JMP = 4'b0101;
  localparam logic [3:0] OP_JC  = 4'b0110;
  localparam logic [3:0] OP_JZ  = 4'b0111;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  stage_e     stage_q;
  stage_e     stage_d;
  logic       halted_q;
  logic       halted_d;
  logic [3:0] op;
  logic       adv;
  logic       last;
  logic       valid;
  logic       go;
  logic       unused_lsbs;
  ctl_t       raw;
  ctl_t       ctl;

  assign op          = opcode_i[OPCODE_W-1 -: 4];
  assign unused_lsbs = ^opcode_i;
  assign adv         = ~step_mode_i | step_i;

  always_ff @(negedge clk_i) begin
    if (reset_i) begin
      stage_q  <= T1;
      halted_q <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      halted_q <= halted_d;
    end
  end

  // Raw per-stage strobes plus the "this is the final T-state" flag.
  always_comb begin
    raw   = '0;
    last  = 1'b0;
    valid = 1'b1;
    unique case (stage_q)
      T1: begin
        raw.pc_en    = 1'b1;
        raw.mem_load = 1'b1;
      end
      T2: raw.pc_inc = 1'b1;
      T3: begin
        raw.mem_en   = 1'b1;
        raw.ins_load = 1'b1;
      end
      T4: begin
        last = 1'b1;
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            raw.ins_en   = 1'b1;
            raw.mem_load = 1'b1;
            last         = 1'b0;
          end
          OP_LDI: begin
            raw.ins_en = 1'b1;
            raw.a_load = 1'b1;
          end
          OP_JMP: begin
            raw.ins_en  = 1'b1;
            raw.pc_load = 1'b1;
          end
          OP_JC: begin
            raw.ins_en  = carry_i;
            raw.pc_load = carry_i;
          end
          OP_JZ: begin
            raw.ins_en  = zero_i;
            raw.pc_load = zero_i;
          end
          OP_OUT: begin
            raw.a_en        = 1'b1;
            raw.output_load = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        last = 1'b1;
        case (op)
          OP_LDA: begin
            raw.mem_en = 1'b1;
            raw.a_load = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            raw.mem_en = 1'b1;
            raw.b_load = 1'b1;
            last       = 1'b0;
          end
          OP_STA: begin
            raw.a_en      = 1'b1;
            raw.mem_write = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        last = 1'b1;
        if (op == OP_ADD || op == OP_SUB) begin
          raw.adder_en   = 1'b1;
          raw.a_load     = 1'b1;
          raw.flags_load = 1'b1;
          raw.adder_sub  = (op == OP_SUB);
        end
      end
      default: valid = 1'b0;
    endcase
  end

  // A finishing HLT parks at T4 instead of wrapping to T1.
  always_comb begin
    stage_d  = stage_q;
    halted_d = halted_q;
    if (reset_i) begin
      stage_d  = T1;
      halted_d = 1'b0;
    end else if (!halted_q && adv) begin
      if (!valid) begin
        stage_d = T1;
      end else if (last) begin
        if (stage_q == T4 && op == OP_HLT) begin
          halted_d = 1'b1;
        end else begin
          stage_d = T1;
        end
      end else begin
        stage_d = stage_e'(stage_q + 1'b1);
      end
    end
  end

  assign go  = adv & ~halted_q & ~reset_i & valid;
  assign ctl = go ? raw : '0;

  assign pc_en_o       = ctl.pc_en;
  assign pc_inc_o      = ctl.pc_inc;
  assign pc_load_o     = ctl.pc_load;
  assign mem_load_o    = ctl.mem_load;
  assign mem_en_o      = ctl.mem_en;
  assign mem_write_o   = ctl.mem_write;
  assign ins_load_o    = ctl.ins_load;
  assign ins_en_o      = ctl.ins_en;
  assign a_load_o      = ctl.a_load;
  assign a_en_o        = ctl.a_en;
  assign b_load_o      = ctl.b_load;
  assign adder_en_o    = ctl.adder_en;
  assign adder_sub_o   = ctl.adder_sub;
  assign flags_load_o  = ctl.flags_load;
  assign output_load_o = ctl.output_load;

  assign halt_o       = halted_q & ~reset_i;
  assign instr_done_o = last & valid & ~halted_q & ~reset_i;
  assign stage_o      = stage_q;

endmodule

// File: tb/tb_sap_controller_ext.sv
// Bench for sap_controller_ext: vector table, random run against
// a reference model, and hand sequences for halt/step/reset.
module tb_sap_controller_ext;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       carry, zero, sm, st;
  logic       pc_en, pc_inc, pc_load, mem_load, mem_en, mem_write;
  logic       ins_load, ins_en, a_load, a_en, b_load;
  logic       adder_en, adder_sub, flags_load, output_load;
  logic       halt, done;
  logic [2:0] stage;
  logic [14:0] strobes;

  always #5 clk = ~clk;

  sap_controller_ext #(.OPCODE_W(6), .STAGE_W(3)) dut (
    .clk_i(clk), .reset_i(reset), .opcode_i(opcode),
    .carry_i(carry), .zero_i(zero),
    .step_mode_i(sm), .step_i(st),
    .pc_en_o(pc_en), .pc_inc_o(pc_inc), .pc_load_o(pc_load),
    .mem_load_o(mem_load), .mem_en_o(mem_en),
    .mem_write_o(mem_write),
    .ins_load_o(ins_load), .ins_en_o(ins_en),
    .a_load_o(a_load), .a_en_o(a_en), .b_load_o(b_load),
    .adder_en_o(adder_en), .adder_sub_o(adder_sub),
    .flags_load_o(flags_load), .output_load_o(output_load),
    .halt_o(halt), .instr_done_o(done), .stage_o(stage)
  );

  assign strobes = {pc_en, pc_inc, pc_load, mem_load, mem_en,
                    mem_write, ins_load, ins_en, a_load, a_en,
                    b_load, adder_en, adder_sub, flags_load,
                    output_load};

  localparam logic [14:0] PC_EN  = 15'h4000;
  localparam logic [14:0] PC_INC = 15'h2000;
  localparam logic [14:0] PC_LD  = 15'h1000;
  localparam logic [14:0] M_LD   = 15'h0800;
  localparam logic [14:0] M_EN   = 15'h0400;
  localparam logic [14:0] M_WR   = 15'h0200;
  localparam logic [14:0] I_LD   = 15'h0100;
  localparam logic [14:0] I_EN   = 15'h0080;
  localparam logic [14:0] A_LD   = 15'h0040;
  localparam logic [14:0] A_EN   = 15'h0020;
  localparam logic [14:0] B_LD   = 15'h0010;
  localparam logic [14:0] AD_EN  = 15'h0008;
  localparam logic [14:0] AD_SUB = 15'h0004;
  localparam logic [14:0] F_LD   = 15'h0002;
  localparam logic [14:0] O_LD   = 15'h0001;

  int total = 0;
  int bad   = 0;

  int m_stage;
  bit m_halt;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  function automatic int ilen(input logic [3:0] op);
    case (op)
      4'd0, 4'd3: return 5;
      4'd1, 4'd2: return 6;
      default:    return 4;
    endcase
  endfunction

  function automatic logic [14:0] spec_ctl(input logic [3:0] op,
                                           input int s,
                                           input logic c,
                                           input logic z);
    case (s)
      0: return PC_EN | M_LD;
      1: return PC_INC;
      2: return M_EN | I_LD;
      3: case (op)
           4'd0, 4'd1, 4'd2, 4'd3: return I_EN | M_LD;
           4'd4:  return I_EN | A_LD;
           4'd5:  return I_EN | PC_LD;
           4'd6:  return c ? (I_EN | PC_LD) : 15'h0;
           4'd7:  return z ? (I_EN | PC_LD) : 15'h0;
           4'd14: return A_EN | O_LD;
           default: return 15'h0;
         endcase
      4: case (op)
           4'd0:       return M_EN | A_LD;
           4'd1, 4'd2: return M_EN | B_LD;
           4'd3:       return A_EN | M_WR;
           default:    return 15'h0;
         endcase
      5: case (op)
           4'd1: return AD_EN | A_LD | F_LD;
           4'd2: return AD_EN | A_LD | F_LD | AD_SUB;
           default: return 15'h0;
         endcase
      default: return 15'h0;
    endcase
  endfunction

  // Compare all outputs with the model in the middle of the cycle.
  task automatic sample(input string tag);
    logic [3:0]  op;
    logic [14:0] e_str;
    logic        e_halt, e_done, adv;
    @(posedge clk);
    #1;
    op  = opcode[5:2];
    adv = !sm || st;
    e_str  = '0;
    e_halt = 1'b0;
    e_done = 1'b0;
    if (!reset) begin
      if (m_halt) begin
        e_halt = 1'b1;
      end else begin
        e_done = (m_stage == ilen(op) - 1);
        if (adv) e_str = spec_ctl(op, m_stage, carry, zero);
      end
    end
    chk({tag, ".stage"},   stage,   m_stage);
    chk({tag, ".strobes"}, strobes, e_str);
    chk({tag, ".halt"},    halt,    e_halt);
    chk({tag, ".done"},    done,    e_done);
  endtask

  task automatic advance();
    logic [3:0] op;
    op = opcode[5:2];
    @(negedge clk);
    if (reset) begin
      m_stage = 0;
      m_halt  = 1'b0;
    end else if (!m_halt && (!sm || st)) begin
      if (m_stage == ilen(op) - 1) begin
        if (op == 4'hF) m_halt = 1'b1;
        else            m_stage = 0;
      end else begin
        m_stage++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample("rst");
    chk("rst.strobes_zero", strobes, 15'h0);
    advance();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic        c;
    logic        z;
    logic [2:0]  stg;
    logic [14:0] str;
    logic        dn;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [3:0] op, input logic c,
                              input logic z, input logic [2:0] s,
                              input logic [14:0] str,
                              input logic dn);
    vec_t v;
    v.op = op; v.c = c; v.z = z; v.stg = s; v.str = str; v.dn = dn;
    tbl.push_back(v);
  endfunction

  function automatic void add_fetch(input logic [3:0] op,
                                    input logic c, input logic z);
    add(op, c, z, 3'd0, PC_EN | M_LD, 1'b0);
    add(op, c, z, 3'd1, PC_INC,       1'b0);
    add(op, c, z, 3'd2, M_EN | I_LD,  1'b0);
  endfunction

  initial begin
    reset  = 1'b1;
    opcode = '0;
    carry  = 1'b0;
    zero   = 1'b0;
    sm     = 1'b0;
    st     = 1'b0;
    m_stage = 0;
    m_halt  = 1'b0;
    @(negedge clk);
    #1;
    do_reset();

    add_fetch(4'd0, 0, 0);
    add(4'd0, 0, 0, 3'd3, I_EN | M_LD, 0);
    add(4'd0, 0, 0, 3'd4, M_EN | A_LD, 1);
    add_fetch(4'd1, 1, 0);
    add(4'd1, 1, 0, 3'd3, I_EN | M_LD, 0);
    add(4'd1, 1, 0, 3'd4, M_EN | B_LD, 0);
    add(4'd1, 1, 0, 3'd5, AD_EN | A_LD | F_LD, 1);
    add_fetch(4'd2, 0, 1);
    add(4'd2, 0, 1, 3'd3, I_EN | M_LD, 0);
    add(4'd2, 0, 1, 3'd4, M_EN | B_LD, 0);
    add(4'd2, 0, 1, 3'd5, AD_EN | AD_SUB | A_LD | F_LD, 1);
    add_fetch(4'd6, 0, 1);
    add(4'd6, 0, 1, 3'd3, 15'h0, 1);
    add_fetch(4'd6, 1, 0);
    add(4'd6, 1, 0, 3'd3, I_EN | PC_LD, 1);
    add_fetch(4'd7, 1, 1);
    add(4'd7, 1, 1, 3'd3, I_EN | PC_LD, 1);
    add_fetch(4'd4, 0, 0);
    add(4'd4, 0, 0, 3'd3, I_EN | A_LD, 1);
    add_fetch(4'd9, 1, 1);
    add(4'd9, 1, 1, 3'd3, 15'h0, 1);

    foreach (tbl[i]) begin
      opcode = {tbl[i].op, 2'($urandom_range(0, 3))};
      carry  = tbl[i].c;
      zero   = tbl[i].z;
      sample("tblmodel");
      chk($sformatf("tbl%0d.stage", i), stage, tbl[i].stg);
      chk($sformatf("tbl%0d.strobes", i), strobes, tbl[i].str);
      chk($sformatf("tbl%0d.done", i), done, tbl[i].dn);
      advance();
    end
    chk("tbl.wrap_t1", stage, 3'd0);

    for (int k = 0; k < 600; k++) begin
      if (m_stage == 0 && !m_halt)
        opcode = 6'($urandom_range(0, 63));
      reset = ($urandom_range(0, 24) == 0) ||
              (m_halt && $urandom_range(0, 3) == 0);
      sm    = ($urandom_range(0, 2) == 0);
      st    = 1'($urandom_range(0, 1));
      carry = 1'($urandom_range(0, 1));
      zero  = 1'($urandom_range(0, 1));
      sample("rand");
      advance();
    end
    reset = 1'b0;
    sm    = 1'b0;

    do_reset();
    opcode = {4'hF, 2'b01};
    for (int k = 0; k < 4; k++) begin
      sample("hlt_run");
      if (k == 3) chk("hlt.t4_done", done, 1'b1);
      advance();
    end
    for (int k = 0; k < 20; k++) begin
      sm = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      sample("hlt_hold");
      chk("hlt.stage3", stage, 3'd3);
      chk("hlt.halt1", halt, 1'b1);
      chk("hlt.quiet", strobes, 15'h0);
      advance();
    end
    sm = 1'b0;
    st = 1'b0;
    do_reset();
    sample("hlt_after");
    chk("hlt.after_stage", stage, 3'd0);
    chk("hlt.after_halt", halt, 1'b0);
    advance();

    do_reset();
    opcode = {4'hE, 2'b10};
    sm = 1'b1;
    for (int p = 0; p < 4; p++) begin
      st = 1'b0;
      for (int k = 0; k < 4; k++) begin
        sample("step_wait");
        chk("step.stall_quiet", strobes, 15'h0);
        chk("step.stall_stage", stage, p);
        advance();
      end
      st = 1'b1;
      sample("step_pulse");
      chk("step.pulse_stage", stage, p);
      chk("step.out_load", output_load, p == 3);
      advance();
    end
    st = 1'b0;
    sample("step_end");
    chk("step.back_t1", stage, 3'd0);
    advance();
    sm = 1'b0;

    do_reset();
    opcode = {4'h3, 2'b11};
    for (int k = 0; k < 4; k++) begin
      sample("sta_run");
      advance();
    end
    reset = 1'b1;
    sample("sta_rst");
    chk("sta.t5_stage", stage, 3'd4);
    chk("sta.mem_write_off", mem_write, 1'b0);
    advance();
    reset = 1'b0;
    sample("sta_post");
    chk("sta.post_stage", stage, 3'd0);
    advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
